i2c_master_nbyte: RTL and testbench



---
 rtl/i2c_master_nbyte.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_master_nbyte.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_nbyte.sv
// Variable-length I2C master (write/read, ACK checking, internal SCL divider).
// Optional SCL clock stretching via the I2C_CLK_STRETCH_EN macro.
module i2c_master_nbyte #(
  parameter int DIV       = 4,
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [6:0]             i_addr,
  input  logic                   i_rw,
  input  logic [LEN_W-1:0]       i_len,
  input  logic [8*MAX_BYTES-1:0] i_wdata,
  input  logic                   i_sclk_in,
  output logic [8*MAX_BYTES-1:0] o_rdata,
  output logic                   o_busy,
  output logic                   o_finished,
  output logic                   o_nack,
  output logic                   o_sclk,
  inout  wire                    io_sdat,
  output logic                   o_oen
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW    = 8 * MAX_BYTES;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WACK,
    S_READ,
    S_RACK,
    S_STOP
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       quarter;
  logic [2:0]       bit_cnt;
  logic [LEN_W-1:0] byte_idx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_clamped;
  logic [6:0]       addr_q;
  logic             rw_q;
  logic [DW-1:0]    wdata_q;
  logic [7:0]       addr_byte;
  logic [7:0]       cur_wbyte;
  logic             ack_bit;
  logic             sda_o;
  logic             stall;
  logic             tick;
  logic             sample_pt;
  logic             slot_end;
  logic             last_byte;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low while we release it freezes the quarter timer.
  assign stall = quarter[1] && o_sclk && !i_sclk_in;
`else
  logic unused_sclk_in;
  assign unused_sclk_in = i_sclk_in;
  assign stall          = 1'b0;
`endif

  assign tick        = (div_cnt == DIV_W'(DIV - 1)) && !stall;
  assign sample_pt   = tick && (quarter == 2'd2);
  assign slot_end    = tick && (quarter == 2'd3);
  assign last_byte   = (byte_idx == len_q - LEN_W'(1));
  assign len_clamped = (i_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : i_len;
  assign addr_byte   = {addr_q, rw_q};
  assign o_busy      = (state != S_IDLE);
  assign io_sdat     = o_oen ? sda_o : 1'bz;

  always_comb begin
    cur_wbyte = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (byte_idx == LEN_W'(k)) cur_wbyte = wdata_q[DW-1-8*k -: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  // Slot sequencing plus the SCL/SDA waveform of the current quarter.
  always_comb begin
    state_n = state;
    o_sclk  = 1'b1;
    o_oen   = 1'b0;
    sda_o   = 1'b1;
    case (state)
      S_IDLE: begin
        if (i_start) state_n = S_START;
      end
      S_START: begin
        o_oen  = 1'b1;
        o_sclk = (quarter != 2'd3);
        sda_o  = !quarter[1];
        if (slot_end) state_n = S_ADDR;
      end
      S_ADDR: begin
        o_oen  = 1'b1;
        o_sclk = quarter[1];
        sda_o  = addr_byte[bit_cnt];
        if (slot_end && bit_cnt == 3'd0) state_n = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        o_sclk = quarter[1];
        if (slot_end) begin
          if (ack_bit || len_q == '0) state_n = S_STOP;
          else if (rw_q)              state_n = S_READ;
          else                        state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        o_oen  = 1'b1;
        o_sclk = quarter[1];
        sda_o  = cur_wbyte[bit_cnt];
        if (slot_end && bit_cnt == 3'd0) state_n = S_WACK;
      end
      S_WACK: begin
        o_sclk = quarter[1];
        if (slot_end) state_n = (ack_bit || last_byte) ? S_STOP : S_WRITE;
      end
      S_READ: begin
        o_sclk = quarter[1];
        if (slot_end && bit_cnt == 3'd0) state_n = S_RACK;
      end
      S_RACK: begin
        o_oen  = 1'b1;
        o_sclk = quarter[1];
        sda_o  = last_byte;
        if (slot_end) state_n = last_byte ? S_STOP : S_READ;
      end
      S_STOP: begin
        o_oen  = 1'b1;
        o_sclk = (quarter != 2'd0);
        sda_o  = (quarter == 2'd3);
        if (slot_end) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // bit_cnt counts 7..0 and wraps back to 7, ready for the next byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt    <= '0;
      quarter    <= '0;
      bit_cnt    <= 3'd7;
      byte_idx   <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      ack_bit    <= 1'b1;
      o_rdata    <= '0;
      o_nack     <= 1'b0;
      o_finished <= 1'b0;
    end else begin
      o_finished <= (state == S_STOP) && slot_end;
      if (state == S_IDLE) begin
        div_cnt <= '0;
        quarter <= '0;
        if (i_start) begin
          addr_q   <= i_addr;
          rw_q     <= i_rw;
          len_q    <= len_clamped;
          wdata_q  <= i_wdata;
          o_nack   <= 1'b0;
          o_rdata  <= '0;
          byte_idx <= '0;
          bit_cnt  <= 3'd7;
        end
      end else begin
        if (tick) begin
          div_cnt <= '0;
          quarter <= quarter + 2'd1;
        end else if (!stall) begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (sample_pt) begin
          ack_bit <= io_sdat;
          if (state == S_READ) begin
            for (int k = 0; k < MAX_BYTES; k++) begin
              if (byte_idx == LEN_W'(k))
                o_rdata[DW-1-8*k -: 8] <= {o_rdata[DW-2-8*k -: 7], io_sdat};
            end
          end
        end
        if (slot_end) begin
          case (state)
            S_ADDR, S_WRITE, S_READ: bit_cnt <= bit_cnt - 3'd1;
            S_ADDR_ACK, S_WACK: if (ack_bit) o_nack <= 1'b1;
            default: ;
          endcase
          if ((state == S_WACK && state_n == S_WRITE) ||
              (state == S_RACK && state_n == S_READ))
            byte_idx <= byte_idx + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// Self-checking bench for i2c_master_nbyte: directed plan scenarios plus random
// transactions checked against a bus-level reference model and slave model.
module tb_i2c_master_nbyte;

  localparam int DIV       = 4;
  localparam int MAX_BYTES = 4;
  localparam int LEN_W     = 3;

`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_EXTRA = 20;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [6:0]       addr = '0;
  logic             rw = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [31:0]      wdata = '0;
  logic             sclk_in;
  logic [31:0]      rdata;
  logic             busy, finished, nack, sclk, oen;
  wire              sdat;
  logic             slv_bit = 1'b1;
  logic             hold = 1'b0;

  // Open-drain emulation: the slave side (with pull-up) drives whenever the master releases.
  assign sclk_in = sclk & ~hold;
  assign sdat    = oen ? 1'bz : slv_bit;

  i2c_master_nbyte #(.DIV(DIV), .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_addr(addr), .i_rw(rw),
    .i_len(len), .i_wdata(wdata), .i_sclk_in(sclk_in), .o_rdata(rdata),
    .o_busy(busy), .o_finished(finished), .o_nack(nack), .o_sclk(sclk),
    .io_sdat(sdat), .o_oen(oen)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0]  sc_addr;
  logic        sc_rw;
  int          sc_n;
  logic [31:0] sc_wdata;
  logic [7:0]  sc_rd [0:3];
  int          sc_nack_at;
  int          accept_cyc;

  int   nrise = 0, n_start = 0, n_stop = 0, fin_count = 0, fin_cyc = 0;
  logic bit_val [0:63];
  logic bit_oen [0:63];
  logic prev_sclk = 1'b1, prev_sda = 1'b1;
  logic mon_clear = 1'b0;

  // Slave behaviour by SCL-slot index p counted from the first address bit.
  function automatic logic slave_value(int p);
    int j, by, b;
    if (p < 8) return 1'b1;
    if (p == 8) return (sc_nack_at == 0) ? 1'b1 : 1'b0;
    if (sc_nack_at == 0) return 1'b1;
    j  = p - 9;
    by = j / 9;
    b  = j % 9;
    if (by >= sc_n) return 1'b1;
    if (sc_rw == 1'b0) begin
      if (b != 8) return 1'b1;
      return (sc_nack_at == by + 1) ? 1'b1 : 1'b0;
    end
    if (b == 8) return 1'b1;
    return sc_rd[by][7-b];
  endfunction

  always @(negedge clk) begin
    if (mon_clear) begin
      nrise = 0; n_start = 0; n_stop = 0; fin_count = 0;
    end else begin
      if (sclk && !prev_sclk) begin
        if (nrise < 64) begin
          bit_val[nrise] = sdat;
          bit_oen[nrise] = oen;
        end
        nrise++;
      end
      if (!sclk && prev_sclk) slv_bit = slave_value(nrise);
      if (!busy) slv_bit = 1'b1;
      if (sclk && prev_sclk && prev_sda && !sdat) n_start++;
      if (sclk && prev_sclk && !prev_sda && sdat) n_stop++;
      if (finished) begin
        fin_count++;
        fin_cyc = cyc;
      end
    end
    prev_sclk = sclk;
    prev_sda  = sdat;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] get_byte(int p0);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[7-b] = bit_val[p0+b];
    return v;
  endfunction

  task automatic applyStimulus(input logic [6:0] a, input logic r, input logic [LEN_W-1:0] l,
                               input logic [31:0] wd, input logic [31:0] rd, input int nack_at);
    sc_addr    = a;
    sc_rw      = r;
    sc_n       = (int'(l) > MAX_BYTES) ? MAX_BYTES : int'(l);
    sc_wdata   = wd;
    sc_nack_at = nack_at;
    for (int j = 0; j < 4; j++) sc_rd[j] = rd[31-8*j -: 8];
    @(posedge clk); #2;
    addr = a; rw = r; len = l; wdata = wd; start = 1'b1; mon_clear = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; mon_clear = 1'b0;
    accept_cyc = cyc;
    checkOutput("busy_after_accept", busy, 1'b1);
    checkOutput("nack_cleared", nack, 1'b0);
    checkOutput("rdata_cleared", rdata, 32'h0);
  endtask

  task automatic waitFinish(input bit pulse_starts);
    for (int i = 0; i < 3000 && fin_count == 0; i++) begin
      @(posedge clk); #2;
      if (pulse_starts) start = ((i % 10) == 9) && busy;
    end
    start = 1'b0;
    checkOutput("finish_within_budget", fin_count > 0, 1'b1);
    repeat (20) @(posedge clk);
    #2;
  endtask

  // Reference model: slot count, NACK, read data and bus bytes from the protocol rules.
  task automatic checkTransaction(input string tag, input int extra);
    int s, nbytes, p0;
    logic exp_nack;
    logic [31:0] exp_rd;
    exp_rd = '0;
    if (sc_nack_at == 0) begin
      s = 11; nbytes = 0; exp_nack = 1'b1;
    end else if (!sc_rw && sc_nack_at > 0 && sc_nack_at <= sc_n) begin
      s = 11 + 9 * sc_nack_at; nbytes = sc_nack_at; exp_nack = 1'b1;
    end else begin
      s = 11 + 9 * sc_n; nbytes = sc_n; exp_nack = 1'b0;
    end
    if (sc_rw && sc_nack_at != 0)
      for (int j = 0; j < sc_n; j++) exp_rd = exp_rd | ({24'h0, sc_rd[j]} << (8 * (3 - j)));
    checkOutput({tag, "_latency"}, fin_cyc - accept_cyc, 4 * DIV * s + extra);
    checkOutput({tag, "_nack"}, nack, exp_nack);
    checkOutput({tag, "_rdata"}, rdata, exp_rd);
    checkOutput({tag, "_busy_end"}, busy, 1'b0);
    checkOutput({tag, "_oen_end"}, oen, 1'b0);
    checkOutput({tag, "_fin_count"}, fin_count, 1);
    checkOutput({tag, "_start_cond"}, n_start, 1);
    checkOutput({tag, "_stop_cond"}, n_stop, 1);
    checkOutput({tag, "_scl_pulses"}, nrise, 10 + 9 * nbytes);
    checkOutput({tag, "_addr_byte"}, get_byte(0), {sc_addr, sc_rw});
    checkOutput({tag, "_addr_ack_oen"}, bit_oen[8], 1'b0);
    for (int j = 0; j < nbytes; j++) begin
      p0 = 9 + 9 * j;
      if (!sc_rw) begin
        checkOutput({tag, "_wbyte"}, get_byte(p0), sc_wdata[31-8*j -: 8]);
        checkOutput({tag, "_wack_oen"}, bit_oen[p0+8], 1'b0);
      end else begin
        checkOutput({tag, "_rbyte_oen"}, bit_oen[p0], 1'b0);
        checkOutput({tag, "_rack_oen"}, bit_oen[p0+8], 1'b1);
        checkOutput({tag, "_rack_val"}, bit_val[p0+8], (j == sc_n - 1) ? 1'b1 : 1'b0);
      end
    end
  endtask

  initial begin
    logic [6:0]       ra;
    logic             rr;
    logic [LEN_W-1:0] rl;
    int               rn, rk, nk;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_sclk", sclk, 1'b1);
    checkOutput("reset_oen", oen, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_finished", finished, 1'b0);
    checkOutput("reset_nack", nack, 1'b0);
    checkOutput("reset_rdata", rdata, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] write 0x1A len 2, all ACK");
    applyStimulus(7'h1A, 1'b0, 3'd2, 32'h1E00_5A5A, 32'h0, -1);
    waitFinish(1'b0);
    checkTransaction("write", 0);
    checkOutput("write_latency_464", fin_cyc - accept_cyc, 464);

    $display("[TB] write with address NACK");
    applyStimulus(7'h1A, 1'b0, 3'd2, 32'h1E00_5A5A, 32'h0, 0);
    waitFinish(1'b0);
    checkTransaction("addr_nack", 0);
    checkOutput("addr_nack_latency_176", fin_cyc - accept_cyc, 176);

    $display("[TB] read 0x1A len 2");
    applyStimulus(7'h1A, 1'b1, 3'd2, 32'h0, 32'hA53C_0000, -1);
    waitFinish(1'b0);
    checkTransaction("read", 0);
    checkOutput("read_rdata_A53C", rdata, 32'hA53C_0000);

    $display("[TB] probe len 0 with extra start pulses");
    applyStimulus(7'h1A, 1'b0, 3'd0, 32'h0, 32'h0, -1);
    waitFinish(1'b1);
    checkTransaction("probe", 0);

    $display("[TB] reset during write bit 3");
    applyStimulus(7'h1A, 1'b0, 3'd2, 32'h1E00_5A5A, 32'h0, -1);
    for (int i = 0; i < 2000 && nrise < 12; i++) @(negedge clk);
    checkOutput("reach_write_bit3", nrise, 12);
    for (int i = 0; i < 100 && sclk; i++) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_sclk", sclk, 1'b1);
    checkOutput("midreset_oen", oen, 1'b0);
    checkOutput("midreset_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(7'h1A, 1'b0, 3'd2, 32'h1E00_5A5A, 32'h0, -1);
    waitFinish(1'b0);
    checkTransaction("after_reset", 0);

    $display("[TB] slave holds SCL low in first write ACK");
    applyStimulus(7'h1A, 1'b0, 3'd2, 32'h1E00_5A5A, 32'h0, -1);
    for (int i = 0; i < 2000 && nrise < 17; i++) @(negedge clk);
    checkOutput("reach_wack0", nrise, 17);
    for (int i = 0; i < 100 && sclk; i++) @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 100 && !sclk; i++) @(negedge clk);
    checkOutput("wack0_scl_high", sclk, 1'b1);
    repeat (20) @(negedge clk);
    hold = 1'b0;
    waitFinish(1'b0);
    checkTransaction("stretch", STRETCH_EXTRA);

    $display("[TB] random transactions");
    for (int t = 0; t < 8; t++) begin
      ra = 7'($urandom);
      rr = 1'($urandom_range(0, 1));
      rl = LEN_W'($urandom_range(0, 7));
      rn = (int'(rl) > MAX_BYTES) ? MAX_BYTES : int'(rl);
      rk = $urandom_range(0, 7);
      if (rk == 0) nk = 0;
      else if (rk <= 2 && !rr && rn > 0) nk = $urandom_range(1, rn);
      else nk = -1;
      applyStimulus(ra, rr, rl, $urandom, $urandom, nk);
      waitFinish(1'b0);
      checkTransaction("rand", 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
